interrupt_ctrl: RTL
===================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. Ports are clock (in, 1, rising-edge system clock) and reset (in, 1, synchronous active-high).
REQ-002 SHALL have these SFR write inputs: wr_addr (in, 8, SFR byte or bit address), data_in (in, 8, write data), wr (in, 1, write strobe) and wr_bit (in, 1, bit-addressed write).
REQ-003 SHALL have these event inputs: tf0 (in, 1, timer-0 overflow flag), tf1 (in, 1, timer-1 overflow flag), int0_n (in, 1, external interrupt 0, active-low) and int1_n (in, 1, external interrupt 1, active-low).
REQ-004 SHALL have these CPU handshake inputs: int_ack (in, 1, CPU accepts the vector) and reti (in, 1, CPU executed RETI, one-cycle pulse).
REQ-005 SHALL have these register outputs: tcon (out, 8, TCON), ie (out, 8, IE) and ip (out, 8, IP).
REQ-006 SHALL have these request outputs: int_req (out, 1, interrupt request to CPU) and int_vec (out, 8, vector address).

Function
REQ-007 Byte write: when wr=1 and wr_bit=0, the byte SHALL be written to TCON, IE or IP if wr_addr equals SFR_TCON (0x88), SFR_IE (0xA8) or SFR_IP (0xB8).
REQ-008 Bit write: when wr=1 and wr_bit=1, the target byte SHALL be {wr_addr[7:3],3'b000}, the bit index wr_addr[2:0], and the written value data_in[0].
REQ-009 TCON bits: TF1=7, TR1=6, TF0=5, TR0=4, IE1=3, IT1=2, IE0=1, IT0=0. IE bits used: EA=7, ET1=3, EX1=2, ET0=1, EX0=0. IP bits used: PT1=3, PX1=2, PT0=1, PX0=0. Unused IE and IP bits SHALL be writable and have no function.
REQ-010 TF0 SHALL be set on the cycle after a 0->1 transition of tf0; tf0 is sampled into a register. TF1 SHALL be set the same way from tf1.
REQ-011 When ITx=1 (edge mode), IEx SHALL be set on the cycle after a registered 1->0 transition of intx_n.
REQ-012 When ITx=0 (level mode), IEx SHALL equal the registered value of !intx_n every cycle; software writes to IEx have no effect in this mode.
REQ-013 If a hardware set and a software write or an ack-clear hit the same flag bit in the same cycle, the hardware set SHALL win.
REQ-014 A source is pending when flag & EA & its enable bit are all 1.
REQ-015 Fixed order within a priority level SHALL be IE0 > TF0 > IE1 > TF1. Vectors: IE0=0x03, TF0=0x0B, IE1=0x13, TF1=0x1B.
REQ-016 In-service state SHALL be two bits, isr_hi and isr_lo.
REQ-017 A high-priority pending source is eligible when isr_hi=0. A low-priority pending source is eligible when isr_hi=0 and isr_lo=0. Any eligible high-priority source SHALL beat any eligible low-priority source.
REQ-018 FSM states SHALL be IDLE and REQ.
REQ-019 IDLE->REQ: on the clock edge after an eligible source exists, int_req SHALL be registered to 1 and int_vec latched to the selected source's vector. Latency from flag set to int_req is 1 cycle.
REQ-020 In REQ, int_vec SHALL stay stable and no re-arbitration SHALL occur until int_ack.
REQ-021 In REQ, if the latched source stops being pending (flag cleared, EA=0 or its enable=0) and int_ack=0, int_req SHALL drop next cycle and the FSM SHALL go to IDLE.
REQ-022 On int_ack=1 in REQ, the next edge SHALL:
  - set isr_hi or isr_lo according to the source's level;
  - clear TF0/TF1, or IE0/IE1 if in edge mode (a level-mode IEx is not cleared);
  - drop int_req and go to IDLE.
REQ-023 int_ack in IDLE SHALL be ignored.
REQ-024 On reti=1, isr_hi SHALL be cleared if set, else isr_lo. reti with neither bit set SHALL have no effect.
REQ-025 If reti and int_ack occur in the same cycle, reti SHALL be applied first, then the ack sets its bit.
REQ-026 tcon, ie and ip SHALL be registered outputs reflecting the state after each edge.

Reset
REQ-027 On reset=1 at a clock edge, the following SHALL be cleared: tcon=0x00, ie=0x00, ip=0x00, int_req=0, int_vec=0x00, isr_hi=0, isr_lo=0, FSM=IDLE, and all edge-sample registers (the tf0/tf1 samples reset to 0, the int0_n/int1_n samples reset to 1).
REQ-028 Reset mid-request SHALL abort the request with no flag cleared by ack.
REQ-029 Reset SHALL override all simultaneous writes and events.

Configuration
REQ-030 The macro INT_PRIORITY_EN SHALL control priority support.
REQ-031 With INT_PRIORITY_EN defined: two-level priority from IP, with isr_hi/isr_lo nesting as specified above.
REQ-032 Without INT_PRIORITY_EN: ip SHALL read 0x00 and IP writes are ignored. All sources are low priority and only isr_lo exists, so there is no nesting.

Verification
REQ-033 Reset, then byte-write IE=0x82 and a 0->1 pulse on tf0 -> TCON[5]=1 next cycle, int_req=1 with int_vec=0x0B one cycle later; int_ack -> TF0=0, int_req=0.
REQ-034 IT0=1, IE=0x81, int0_n 1->0 held low -> IE0 is set once; after ack, IE0=0 and stays 0 while int0_n is low. With IT0=0, IE0 re-asserts and a second request follows.
REQ-035 IE=0x8F, IP=0x00, TF1 and IE0 set simultaneously -> int_vec=0x03 first; after ack, no new request until reti; then int_vec=0x1B.
REQ-036 INT_PRIORITY_EN defined, IP=0x08, TF0 in service (low) -> TF1 event gives int_req with int_vec=0x1B (nesting). Without the macro -> no request until reti.
REQ-037 int_req=1 for TF0, then a bit write clears ET0 (wr_addr=0xA9, data_in=0x00) -> int_req=0 next cycle, FSM in IDLE, TF0 still 1.
REQ-038 Bit write TCON.TF0=0 in the same cycle as a tf0 rising-edge set -> TF0=1.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: TCON/IE/IP special-function registers and a four-source interrupt arbiter.
// Define INT_PRIORITY_EN to enable IP-driven two-level priority with isr_hi/isr_lo nesting.
module interrupt_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] wr_addr,
  input  logic [7:0] data_in,
  input  logic       wr,
  input  logic       wr_bit,
  input  logic       tf0,
  input  logic       tf1,
  input  logic       int0_n,
  input  logic       int1_n,
  input  logic       int_ack,
  input  logic       reti,
  output logic [7:0] tcon,
  output logic [7:0] ie,
  output logic [7:0] ip,
  output logic       int_req,
  output logic [7:0] int_vec
);

  localparam logic [7:0] SFR_TCON = 8'h88;
  localparam logic [7:0] SFR_IE   = 8'hA8;
  localparam logic [7:0] SFR_IP   = 8'hB8;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t     state_r, state_s;
  logic       tf0_q_r, tf1_q_r, int0_n_q_r, int1_n_q_r;
  logic       isr_hi_r, isr_lo_r, isr_hi_s, isr_lo_s;
  logic [1:0] src_r, src_s;
  logic       src_hi_r, src_hi_s;
  logic [7:0] tcon_s, ie_s, ip_s, int_vec_s;
  logic       int_req_s;
  logic [3:0] flag_s, pend_s, prio_s, elig_hi_s, elig_lo_s;

  function automatic logic [7:0] sfr_write(input logic [7:0] cur, input logic [7:0] sfr,
                                           input logic we, input logic bit_we,
                                           input logic [7:0] addr, input logic [7:0] din);
    logic [7:0] res;
    res = cur;
    if (we && !bit_we && (addr == sfr)) begin
      res = din;
    end else if (we && bit_we && ({addr[7:3], 3'b000} == sfr)) begin
      res[addr[2:0]] = din[0];
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Source index order is also the fixed priority: 0=IE0, 1=TF0, 2=IE1, 3=TF1.
  function automatic logic [1:0] first_src(input logic [3:0] mask);
    logic [1:0] idx;
    casez (mask)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [7:0] src_vector(input logic [1:0] src);
    logic [7:0] vec;
    case (src)
      2'd0:    vec = 8'h03;
      2'd1:    vec = 8'h0B;
      2'd2:    vec = 8'h13;
      2'd3:    vec = 8'h1B;
      default: vec = 8'h00;
    endcase
    return vec;
  endfunction

  function automatic logic [2:0] flag_pos(input logic [1:0] src);
    logic [2:0] pos;
    case (src)
      2'd0:    pos = 3'd1;
      2'd1:    pos = 3'd5;
      2'd2:    pos = 3'd3;
      2'd3:    pos = 3'd7;
      default: pos = 3'd1;
    endcase
    return pos;
  endfunction

  assign flag_s = {tcon[7], tcon[3], tcon[5], tcon[1]};
  assign pend_s = flag_s & ie[3:0] & {4{ie[7]}};
`ifdef INT_PRIORITY_EN
  assign prio_s = ip[3:0];
`else
  assign prio_s = 4'b0000;
`endif
  assign elig_hi_s = pend_s & prio_s & {4{~isr_hi_r}};
  assign elig_lo_s = pend_s & ~prio_s & {4{~isr_hi_r & ~isr_lo_r}};

  // Next-state: SFR writes, RETI/ack in-service update, request FSM, then hardware flag events.
  always_comb begin
    state_s   = state_r;
    int_req_s = int_req;
    int_vec_s = int_vec;
    src_s     = src_r;
    src_hi_s  = src_hi_r;
    isr_hi_s  = isr_hi_r;
    isr_lo_s  = isr_lo_r;
    tcon_s    = sfr_write(tcon, SFR_TCON, wr, wr_bit, wr_addr, data_in);
    ie_s      = sfr_write(ie, SFR_IE, wr, wr_bit, wr_addr, data_in);
`ifdef INT_PRIORITY_EN
    ip_s      = sfr_write(ip, SFR_IP, wr, wr_bit, wr_addr, data_in);
`else
    ip_s      = 8'h00;
`endif

    if (reti && isr_hi_r) begin
      isr_hi_s = 1'b0;
    end else if (reti && isr_lo_r) begin
      isr_lo_s = 1'b0;
    end else begin
      isr_hi_s = isr_hi_r;
    end

    case (state_r)
      IDLE: begin
        if (|elig_hi_s) begin
          state_s   = REQ;
          int_req_s = 1'b1;
          src_s     = first_src(elig_hi_s);
          src_hi_s  = 1'b1;
          int_vec_s = src_vector(first_src(elig_hi_s));
        end else if (|elig_lo_s) begin
          state_s   = REQ;
          int_req_s = 1'b1;
          src_s     = first_src(elig_lo_s);
          src_hi_s  = 1'b0;
          int_vec_s = src_vector(first_src(elig_lo_s));
        end else begin
          int_req_s = 1'b0;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_s   = IDLE;
          int_req_s = 1'b0;
          if (src_hi_r) begin
            isr_hi_s = 1'b1;
          end else begin
            isr_lo_s = 1'b1;
          end
          // Level-mode IEx is rewritten from the pin below, so an unconditional clear is safe.
          tcon_s[flag_pos(src_r)] = 1'b0;
        end else if (!pend_s[src_r]) begin
          state_s   = IDLE;
          int_req_s = 1'b0;
        end else begin
          state_s   = REQ;
        end
      end
      default: begin
        state_s   = IDLE;
        int_req_s = 1'b0;
      end
    endcase

    if (tf0 && !tf0_q_r) begin
      tcon_s[5] = 1'b1;
    end else begin
      tcon_s[5] = tcon_s[5];
    end
    if (tf1 && !tf1_q_r) begin
      tcon_s[7] = 1'b1;
    end else begin
      tcon_s[7] = tcon_s[7];
    end
    if (!tcon[0]) begin
      tcon_s[1] = ~int0_n;
    end else if (int0_n_q_r && !int0_n) begin
      tcon_s[1] = 1'b1;
    end else begin
      tcon_s[1] = tcon_s[1];
    end
    if (!tcon[2]) begin
      tcon_s[3] = ~int1_n;
    end else if (int1_n_q_r && !int1_n) begin
      tcon_s[3] = 1'b1;
    end else begin
      tcon_s[3] = tcon_s[3];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      tcon       <= 8'h00;
      ie         <= 8'h00;
      ip         <= 8'h00;
      int_req    <= 1'b0;
      int_vec    <= 8'h00;
      src_r      <= 2'd0;
      src_hi_r   <= 1'b0;
      isr_hi_r   <= 1'b0;
      isr_lo_r   <= 1'b0;
      tf0_q_r    <= 1'b0;
      tf1_q_r    <= 1'b0;
      int0_n_q_r <= 1'b1;
      int1_n_q_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      tcon       <= tcon_s;
      ie         <= ie_s;
      ip         <= ip_s;
      int_req    <= int_req_s;
      int_vec    <= int_vec_s;
      src_r      <= src_s;
      src_hi_r   <= src_hi_s;
      isr_hi_r   <= isr_hi_s;
      isr_lo_r   <= isr_lo_s;
      tf0_q_r    <= tf0;
      tf1_q_r    <= tf1;
      int0_n_q_r <= int0_n;
      int1_n_q_r <= int1_n;
    end
  end

endmodule
